// File: rtl/output_port_tx.sv
// rtl/output_port_tx.sv - router output link transmitter: flit FIFO, per-VC on/off throttle, VC ownership tracking
// Optional protocol checker: define TX_PROTOCOL_CHECK_EN to add the sticky err_o output.
module output_port_tx #(
    parameter int VC_NUM         = 2,
    parameter int FLIT_DATA_W    = 32,
    parameter int TX_BUFFER_SIZE = 4,
    localparam int VC_W          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   head_i,
    input  logic                   tail_i,
    input  logic [VC_W-1:0]        vc_id_i,
    input  logic [FLIT_DATA_W-1:0] data_i,
    output logic                   ready_o,
    input  logic [VC_NUM-1:0]      vc_reserve_i,
    input  logic [VC_NUM-1:0]      on_off_i,
    input  logic [VC_NUM-1:0]      vc_allocatable_i,
    output logic                   valid_flit_o,
    output logic                   head_o,
    output logic                   tail_o,
    output logic [VC_W-1:0]        vc_id_o,
    output logic [FLIT_DATA_W-1:0] data_o,
    output logic [VC_NUM-1:0]      vc_available_o,
    output logic [VC_NUM-1:0]      on_off_o
`ifdef TX_PROTOCOL_CHECK_EN
    ,
    output logic                   err_o
`endif
);

    localparam int PTR_W = $clog2(TX_BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESERVED = 2'd1,
        ST_ACTIVE   = 2'd2
    } vc_state_t;

    logic [FLIT_DATA_W-1:0] buf_data [TX_BUFFER_SIZE];
    logic                   buf_head [TX_BUFFER_SIZE];
    logic                   buf_tail [TX_BUFFER_SIZE];
    logic [VC_W-1:0]        buf_vc   [TX_BUFFER_SIZE];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [VC_NUM-1:0] on_off_q;
    logic [VC_NUM-1:0] alloc_q;
    vc_state_t         vc_state [VC_NUM];

    logic              full;
    logic              push;
    logic              pop;
    logic              pop_tail;
    logic [VC_W-1:0]   pop_vc;
    logic [VC_NUM-1:0] push_vc;
    logic [VC_NUM-1:0] head_push_vc;
    logic [VC_NUM-1:0] tail_pop_vc;

    // Pointers wrap naturally because the depth is a power of two.
    assign full     = (count == CNT_W'(TX_BUFFER_SIZE));
    assign ready_o  = !full;
    assign push     = valid_i && !full;
    assign pop_tail = buf_tail[rd_ptr];
    assign pop_vc   = buf_vc[rd_ptr];
    // Strictly in-order: a blocked head entry stalls every VC behind it.
    assign pop      = (count != '0) && on_off_q[pop_vc];
    assign on_off_o = on_off_q;

    // Decode push/pop events per VC for the ownership FSMs.
    always_comb begin
        push_vc      = '0;
        head_push_vc = '0;
        tail_pop_vc  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            push_vc[v]      = push && (vc_id_i == VC_W'(v));
            head_push_vc[v] = push_vc[v] && head_i && !tail_i;
            tail_pop_vc[v]  = pop && pop_tail && (pop_vc == VC_W'(v));
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= data_i;
                buf_head[wr_ptr] <= head_i;
                buf_tail[wr_ptr] <= tail_i;
                buf_vc[wr_ptr]   <= vc_id_i;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Link output registers; payload fields hold when nothing is sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_flit_o <= 1'b0;
            head_o       <= 1'b0;
            tail_o       <= 1'b0;
            vc_id_o      <= '0;
            data_o       <= '0;
        end else begin
            valid_flit_o <= pop;
            if (pop) begin
                head_o  <= buf_head[rd_ptr];
                tail_o  <= buf_tail[rd_ptr];
                vc_id_o <= buf_vc[rd_ptr];
                data_o  <= buf_data[rd_ptr];
            end
        end
    end

    // Downstream feedback sampled every cycle; reset assumes everything open.
    always_ff @(posedge clk) begin
        if (rst) begin
            on_off_q <= '1;
            alloc_q  <= '1;
        end else begin
            on_off_q <= on_off_i;
            alloc_q  <= vc_allocatable_i;
        end
    end

    // Per-VC ownership FSM; a tail pop releases first so a same-cycle reserve re-claims the VC.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (rst) begin
                vc_state[v] <= ST_IDLE;
            end else begin
                case (vc_state[v])
                    ST_IDLE: begin
                        if (vc_reserve_i[v]) vc_state[v] <= ST_RESERVED;
                    end
                    ST_RESERVED: begin
                        if (tail_pop_vc[v])
                            vc_state[v] <= vc_reserve_i[v] ? ST_RESERVED : ST_IDLE;
                        else if (head_push_vc[v])
                            vc_state[v] <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (tail_pop_vc[v])
                            vc_state[v] <= vc_reserve_i[v] ? ST_RESERVED : ST_IDLE;
                    end
                    default: vc_state[v] <= ST_IDLE;
                endcase
            end
        end
    end

    // A VC is offered to the local allocator only when unowned and open downstream.
    always_comb begin
        vc_available_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            vc_available_o[v] = (vc_state[v] == ST_IDLE) && alloc_q[v];
        end
    end

`ifdef TX_PROTOCOL_CHECK_EN
    logic proto_err;

    // Flag upstream protocol violations; a VC releasing this cycle counts as idle for reserve.
    always_comb begin
        proto_err = valid_i && full;
        if ((vc_reserve_i & (vc_reserve_i - VC_NUM'(1))) != '0) proto_err = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            if (vc_reserve_i[v] && (vc_state[v] != ST_IDLE) && !tail_pop_vc[v]) proto_err = 1'b1;
            if (push_vc[v]) begin
                if (vc_state[v] == ST_IDLE) proto_err = 1'b1;
                if (head_i && (vc_state[v] == ST_ACTIVE)) proto_err = 1'b1;
                if (!head_i && (vc_state[v] == ST_RESERVED)) proto_err = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) err_o <= 1'b0;
        else if (proto_err) err_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_output_port_tx.sv
// tb/tb_output_port_tx.sv - scoreboard testbench for output_port_tx
module tb_output_port_tx;

    localparam int VC_NUM = 2;
    localparam int DW     = 32;
    localparam int FW     = 2 + 1 + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          head_i;
    logic          tail_i;
    logic [0:0]    vc_id_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic [1:0]    vc_reserve_i;
    logic [1:0]    on_off_i;
    logic [1:0]    vc_allocatable_i;
    logic          valid_flit_o;
    logic          head_o;
    logic          tail_o;
    logic [0:0]    vc_id_o;
    logic [DW-1:0] data_o;
    logic [1:0]    vc_available_o;
    logic [1:0]    on_off_o;
`ifdef TX_PROTOCOL_CHECK_EN
    logic          err_o;
`endif

    output_port_tx #(.VC_NUM(VC_NUM), .FLIT_DATA_W(DW), .TX_BUFFER_SIZE(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .head_i(head_i), .tail_i(tail_i),
        .vc_id_i(vc_id_i), .data_i(data_i), .ready_o(ready_o), .vc_reserve_i(vc_reserve_i),
        .on_off_i(on_off_i), .vc_allocatable_i(vc_allocatable_i), .valid_flit_o(valid_flit_o),
        .head_o(head_o), .tail_o(tail_o), .vc_id_o(vc_id_o), .data_o(data_o),
        .vc_available_o(vc_available_o), .on_off_o(on_off_o)
`ifdef TX_PROTOCOL_CHECK_EN
        , .err_o(err_o)
`endif
    );

    always #5 clk = ~clk;

    logic [FW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int out_mark;

    // Monitor: every link flit is matched against the oldest expected flit.
    always @(negedge clk) begin
        logic [FW-1:0] got;
        logic [FW-1:0] exp;
        if (valid_flit_o) begin
            got = {head_o, tail_o, vc_id_o, data_o};
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_flit got=%h exp=none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL link_flit got=%h exp=%h", got, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reserve(input logic [1:0] r);
        vc_reserve_i = r;
        tick();
        vc_reserve_i = 2'b00;
    endtask

    task automatic push_flit(input logic h, input logic t, input logic v, input logic [DW-1:0] d);
        valid_i = 1'b1;
        head_i  = h;
        tail_i  = t;
        vc_id_i = v;
        data_i  = d;
        exp_q.push_back({h, t, v, d});
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 0; head_i = 0; tail_i = 0; vc_id_i = 0; data_i = '0;
        vc_reserve_i = 2'b00; on_off_i = 2'b00; vc_allocatable_i = 2'b11;

        // Reset state: on/off copy forced open even though inputs are low.
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", valid_flit_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_on_off", on_off_o, 2'b11);
        check("rst_avail", vc_available_o, 2'b11);
        check("rst_data", data_o, 0);
        on_off_i = 2'b11;
        rst = 1'b0;
        tick();

        // Three-flit packet on VC1, latency and ownership.
        reserve(2'b10);
        @(negedge clk);
        check("t1_avail_reserved", vc_available_o, 2'b01);
        push_flit(1, 0, 1, 32'hA1);
        @(negedge clk);
        check("t1_latency_t1", valid_flit_o, 0);
        check("t1_avail_active", vc_available_o, 2'b01);
        push_flit(0, 0, 1, 32'hA2);
        @(negedge clk);
        check("t1_latency_t2", valid_flit_o, 1);
        push_flit(0, 1, 1, 32'hA3);
        repeat (4) tick();
        @(negedge clk);
        check("t1_avail_released", vc_available_o, 2'b11);
        check("t1_drained", exp_q.size(), 0);

        // VC0 throttled off, then released.
        on_off_i = 2'b10;
        reserve(2'b01);
        push_flit(1, 0, 0, 32'hB1);
        push_flit(0, 0, 0, 32'hB2);
        push_flit(0, 1, 0, 32'hB3);
        repeat (4) begin
            @(negedge clk);
            check("t2_blocked", valid_flit_o, 0);
        end
        @(posedge clk);
        #1;
        on_off_i = 2'b11;
        @(negedge clk);
        check("t2_on_lat0", valid_flit_o, 0);
        @(negedge clk);
        check("t2_on_lat1", valid_flit_o, 0);
        @(negedge clk);
        check("t2_on_lat2", valid_flit_o, 1);
        repeat (4) tick();
        check("t2_drained", exp_q.size(), 0);
        check("t2_avail", vc_available_o, 2'b11);

        // Fill to full on VC1, extra valid ignored, then exactly four out.
        on_off_i = 2'b01;
        reserve(2'b10);
        push_flit(1, 0, 1, 32'hC1);
        push_flit(0, 0, 1, 32'hC2);
        push_flit(0, 0, 1, 32'hC3);
        push_flit(0, 1, 1, 32'hC4);
        @(negedge clk);
        check("t3_full_ready", ready_o, 0);
        valid_i = 1; head_i = 0; tail_i = 0; vc_id_i = 1; data_i = 32'hEE;
        tick();
        valid_i = 0;
        @(negedge clk);
        check("t3_still_full", ready_o, 0);
        out_mark = n_out;
        on_off_i = 2'b11;
        repeat (8) tick();
        check("t3_out_count", n_out - out_mark, 4);
        check("t3_ready_back", ready_o, 1);
        check("t3_avail", vc_available_o, 2'b11);

        // Single-flit packet on VC0 with re-reserve in the tail-pop cycle.
        on_off_i = 2'b10;
        reserve(2'b01);
        push_flit(1, 1, 0, 32'h55);
        repeat (2) tick();
        on_off_i = 2'b11;
        tick();
        vc_reserve_i = 2'b01;
        tick();
        vc_reserve_i = 2'b00;
        @(negedge clk);
        check("t4_pop", valid_flit_o, 1);
        check("t4_avail_rereserved", vc_available_o, 2'b10);
        repeat (3) tick();
        check("t4_avail_hold", vc_available_o, 2'b10);

        // Reset in the middle of a queued packet.
        on_off_i = 2'b01;
        reserve(2'b10);
        push_flit(1, 0, 1, 32'hD1);
        push_flit(0, 0, 1, 32'hD2);
        rst = 1'b1;
        exp_q.delete();
        on_off_i = 2'b11;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid", valid_flit_o, 0);
        check("t5_ready", ready_o, 1);
        check("t5_avail", vc_available_o, 2'b11);
        repeat (5) tick();
        check("t5_no_output", exp_q.size(), 0);

`ifdef TX_PROTOCOL_CHECK_EN
        // Body flit to an idle VC raises the sticky error.
        @(negedge clk);
        check("t6_err_clear", err_o, 0);
        push_flit(0, 0, 1, 32'h77);
        @(negedge clk);
        check("t6_err_set", err_o, 1);
        repeat (4) tick();
        check("t6_err_sticky", err_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_err_rst", err_o, 0);
        exp_q.delete();
`endif

        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
